// File: rtl/circle_pkg.sv
// circle_pkg: shared types and constants for the midpoint circle/arc plotter.
// State encoding, octant ordering and mask-bit positions live here so the
// top level and the octant mapper agree on a single definition.
package circle_pkg;

  // Control states of the plotter.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_PLOT  = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Octant visiting order: index k in PLOT draws the octant named here.
  localparam logic [2:0] OCT_1 = 3'd0;
  localparam logic [2:0] OCT_2 = 3'd1;
  localparam logic [2:0] OCT_4 = 3'd2;
  localparam logic [2:0] OCT_3 = 3'd3;
  localparam logic [2:0] OCT_5 = 3'd4;
  localparam logic [2:0] OCT_6 = 3'd5;
  localparam logic [2:0] OCT_8 = 3'd6;
  localparam logic [2:0] OCT_7 = 3'd7;
  localparam logic [2:0] OCT_LAST = OCT_7;

  // oct_mask bit positions, one per octant, in the same visiting order.
  localparam logic [7:0] MASK_OCT_1 = 8'h01;
  localparam logic [7:0] MASK_OCT_2 = 8'h02;
  localparam logic [7:0] MASK_OCT_4 = 8'h04;
  localparam logic [7:0] MASK_OCT_3 = 8'h08;
  localparam logic [7:0] MASK_OCT_5 = 8'h10;
  localparam logic [7:0] MASK_OCT_6 = 8'h20;
  localparam logic [7:0] MASK_OCT_8 = 8'h40;
  localparam logic [7:0] MASK_OCT_7 = 8'h80;

  // Larger of two widths; used to size the signed coordinate datapath.
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/circle_octant_map.sv
// circle_octant_map: purely combinational reflection of the first-octant
// offset pair (offset_x, offset_y) about the centre into the octant selected
// by oct_idx. Coordinates are signed and two bits wider than the widest
// operand, so centre +/- offset can never overflow; on_screen reports
// whether the resulting point lies inside the visible area.
module circle_octant_map
  import circle_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XS_W     = max_w(X_W, R_W) + 2,
  parameter int YS_W     = max_w(Y_W, R_W) + 2
) (
  input  logic [2:0]              oct_idx,
  input  logic [X_W-1:0]          centre_x,
  input  logic [Y_W-1:0]          centre_y,
  input  logic [R_W-1:0]          offset_x,
  input  logic [R_W-1:0]          offset_y,
  output logic signed [XS_W-1:0]  x,
  output logic signed [YS_W-1:0]  y,
  output logic                    on_screen
);

  logic signed [XS_W-1:0] cx_s;
  logic signed [XS_W-1:0] ox_x_s;
  logic signed [XS_W-1:0] oy_x_s;
  logic signed [YS_W-1:0] cy_s;
  logic signed [YS_W-1:0] ox_y_s;
  logic signed [YS_W-1:0] oy_y_s;

  // Zero-extend all unsigned operands into the signed coordinate domain.
  assign cx_s   = $signed({{(XS_W-X_W){1'b0}}, centre_x});
  assign ox_x_s = $signed({{(XS_W-R_W){1'b0}}, offset_x});
  assign oy_x_s = $signed({{(XS_W-R_W){1'b0}}, offset_y});
  assign cy_s   = $signed({{(YS_W-Y_W){1'b0}}, centre_y});
  assign ox_y_s = $signed({{(YS_W-R_W){1'b0}}, offset_x});
  assign oy_y_s = $signed({{(YS_W-R_W){1'b0}}, offset_y});

  // Reflect the offset pair into the octant being drawn this cycle.
  always_comb begin
    x = cx_s;
    y = cy_s;
    case (oct_idx)
      OCT_1: begin x = cx_s + ox_x_s; y = cy_s + oy_y_s; end
      OCT_2: begin x = cx_s + oy_x_s; y = cy_s + ox_y_s; end
      OCT_4: begin x = cx_s - ox_x_s; y = cy_s + oy_y_s; end
      OCT_3: begin x = cx_s - oy_x_s; y = cy_s + ox_y_s; end
      OCT_5: begin x = cx_s - ox_x_s; y = cy_s - oy_y_s; end
      OCT_6: begin x = cx_s - oy_x_s; y = cy_s - ox_y_s; end
      OCT_8: begin x = cx_s + ox_x_s; y = cy_s - oy_y_s; end
      OCT_7: begin x = cx_s + oy_x_s; y = cy_s - ox_y_s; end
      default: begin x = cx_s; y = cy_s; end
    endcase
  end

  // Negative values are caught by the sign bit before the upper-bound compare.
  assign on_screen = !x[XS_W-1] && !y[YS_W-1] &&
                     (x < $signed(XS_W'(SCREEN_W))) &&
                     (y < $signed(YS_W'(SCREEN_H)));

endmodule

// File: rtl/circle_arc.sv
// circle_arc: midpoint circle / arc plotter for a small VGA frame buffer.
// A request latches centre, radius, colour and octant mask, then walks the
// first-octant midpoint algorithm, spending exactly eight PLOT cycles per
// iteration (one per octant) so timing is independent of mask and clipping.
// Optional build macro CIRCLE_CLIP_EN: off-screen pixels are suppressed
// (vga_plot=0) instead of being wrapped to X_W/Y_W bits.
module circle_arc
  import circle_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [X_W-1:0]  centre_x,
  input  logic [Y_W-1:0]  centre_y,
  input  logic [R_W-1:0]  radius,
  input  logic [2:0]      colour,
  input  logic [7:0]      oct_mask,
  output logic            done,
  output logic [X_W-1:0]  vga_x,
  output logic [Y_W-1:0]  vga_y,
  output logic [2:0]      vga_colour,
  output logic            vga_plot
);

  localparam int XS_W = max_w(X_W, R_W) + 2;
  localparam int YS_W = max_w(Y_W, R_W) + 2;
  localparam int CW   = R_W + 3;

  state_t                 state_r;
  state_t                 state_next_s;

  logic [X_W-1:0]         cx_r;
  logic [Y_W-1:0]         cy_r;
  logic [R_W-1:0]         rad_r;
  logic [2:0]             col_r;
  logic [7:0]             mask_r;

  logic [R_W-1:0]         offset_x_r;
  logic [R_W-1:0]         offset_y_r;
  logic signed [CW-1:0]   crit_r;
  logic [2:0]             oct_idx_r;

  logic [R_W-1:0]         oy_inc_s;
  logic [R_W-1:0]         ox_next_s;
  logic                   crit_le0_s;
  logic signed [CW-1:0]   delta_s;
  logic signed [CW-1:0]   crit_step_s;
  logic signed [CW-1:0]   crit_init_s;

  logic signed [XS_W-1:0] px_s;
  logic signed [YS_W-1:0] py_s;
  logic                   on_screen_s;
  logic                   pix_en_s;
  logic                   unused_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; DONE waits for start to drop so a held start cannot retrigger.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_INIT;
        else       state_next_s = ST_IDLE;
      end
      ST_INIT:  state_next_s = ST_CHECK;
      ST_CHECK: begin
        if (offset_y_r <= offset_x_r) state_next_s = ST_PLOT;
        else                          state_next_s = ST_DONE;
      end
      ST_PLOT: begin
        if (oct_idx_r == OCT_LAST) state_next_s = ST_STEP;
        else                       state_next_s = ST_PLOT;
      end
      ST_STEP:  state_next_s = ST_CHECK;
      ST_DONE: begin
        if (!start) state_next_s = ST_IDLE;
        else        state_next_s = ST_DONE;
      end
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Midpoint decision arithmetic for the STEP update and the INIT seed.
  always_comb begin
    oy_inc_s   = offset_y_r + {{(R_W-1){1'b0}}, 1'b1};
    crit_le0_s = crit_r[CW-1] || (crit_r == {CW{1'b0}});
    if (crit_le0_s) begin
      ox_next_s = offset_x_r;
    end else if (offset_x_r == {R_W{1'b0}}) begin
      // Only reachable with radius 0; holding at zero still ends the loop.
      ox_next_s = offset_x_r;
    end else begin
      ox_next_s = offset_x_r - {{(R_W-1){1'b0}}, 1'b1};
    end
    if (crit_le0_s) begin
      delta_s = $signed({{(CW-R_W){1'b0}}, oy_inc_s});
    end else begin
      delta_s = $signed({{(CW-R_W){1'b0}}, oy_inc_s}) -
                $signed({{(CW-R_W){1'b0}}, ox_next_s});
    end
    crit_step_s = crit_r + (delta_s <<< 1) + $signed({{(CW-1){1'b0}}, 1'b1});
    crit_init_s = $signed({{(CW-1){1'b0}}, 1'b1}) -
                  $signed({{(CW-R_W){1'b0}}, rad_r});
  end

  // Request latch, offsets, decision variable and octant counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_r       <= {X_W{1'b0}};
      cy_r       <= {Y_W{1'b0}};
      rad_r      <= {R_W{1'b0}};
      col_r      <= 3'd0;
      mask_r     <= 8'h00;
      offset_x_r <= {R_W{1'b0}};
      offset_y_r <= {R_W{1'b0}};
      crit_r     <= {CW{1'b0}};
      oct_idx_r  <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cx_r   <= centre_x;
            cy_r   <= centre_y;
            rad_r  <= radius;
            col_r  <= colour;
            mask_r <= oct_mask;
          end
        end
        ST_INIT: begin
          offset_y_r <= {R_W{1'b0}};
          offset_x_r <= rad_r;
          crit_r     <= crit_init_s;
        end
        ST_CHECK: oct_idx_r <= OCT_1;
        ST_PLOT:  oct_idx_r <= oct_idx_r + 3'd1;
        ST_STEP: begin
          offset_y_r <= oy_inc_s;
          offset_x_r <= ox_next_s;
          crit_r     <= crit_step_s;
        end
        default: begin
          oct_idx_r <= oct_idx_r;
        end
      endcase
    end
  end

  circle_octant_map #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .R_W      (R_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .XS_W     (XS_W),
    .YS_W     (YS_W)
  ) u_octant_map (
    .oct_idx   (oct_idx_r),
    .centre_x  (cx_r),
    .centre_y  (cy_r),
    .offset_x  (offset_x_r),
    .offset_y  (offset_y_r),
    .x         (px_s),
    .y         (py_s),
    .on_screen (on_screen_s)
  );

`ifdef CIRCLE_CLIP_EN
  assign pix_en_s = mask_r[oct_idx_r] & on_screen_s;
`else
  assign pix_en_s = mask_r[oct_idx_r];
`endif

  // Upper coordinate bits only matter for the on-screen test.
  assign unused_s = ^{on_screen_s, px_s[XS_W-1:X_W], py_s[YS_W-1:Y_W]};

  // Registered pixel bus and completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= {X_W{1'b0}};
      vga_y      <= {Y_W{1'b0}};
      vga_colour <= 3'd0;
    end else begin
      done <= (state_next_s == ST_DONE);
      if (state_r == ST_PLOT) begin
        vga_plot   <= pix_en_s;
        vga_x      <= px_s[X_W-1:0];
        vga_y      <= py_s[Y_W-1:0];
        vga_colour <= col_r;
      end else begin
        vga_plot   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_circle_arc.sv
// tb_circle_arc: randomized and directed draws checked cycle by cycle against
// an integer midpoint-circle reference model. Honours CIRCLE_CLIP_EN.
module tb_circle_arc;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int R_W = 8;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [X_W-1:0] centre_x;
  logic [Y_W-1:0] centre_y;
  logic [R_W-1:0] radius;
  logic [2:0]     colour;
  logic [7:0]     oct_mask;
  logic           done;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_x[$];
  int exp_y[$];
  int exp_p[$];

  always #5 clk = ~clk;

  circle_arc #(
    .X_W(X_W), .Y_W(Y_W), .R_W(R_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .colour(colour), .oct_mask(oct_mask), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  task automatic check_val(input string tag, input logic [31:0] actual,
                           input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference: one 8-slot group per midpoint iteration, in octant order.
  task automatic build_model(input int cx, input int cy, input int r,
                             input logic [7:0] mask, output int iters);
    int ox, oy, crit, dx, dy, px, py, en;
    exp_x.delete(); exp_y.delete(); exp_p.delete();
    ox = r; oy = 0; crit = 1 - r; iters = 0;
    while (oy <= ox) begin
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: begin dx =  ox; dy =  oy; end
          1: begin dx =  oy; dy =  ox; end
          2: begin dx = -ox; dy =  oy; end
          3: begin dx = -oy; dy =  ox; end
          4: begin dx = -ox; dy = -oy; end
          5: begin dx = -oy; dy = -ox; end
          6: begin dx =  ox; dy = -oy; end
          default: begin dx = oy; dy = -ox; end
        endcase
        px = cx + dx;
        py = cy + dy;
        en = mask[k] ? 1 : 0;
`ifdef CIRCLE_CLIP_EN
        if (px < 0 || px >= SCREEN_W || py < 0 || py >= SCREEN_H) en = 0;
`endif
        exp_p.push_back(en);
        exp_x.push_back(px & ((1 << X_W) - 1));
        exp_y.push_back(py & ((1 << Y_W) - 1));
      end
      iters++;
      oy++;
      if (crit <= 0) begin
        crit = crit + 2 * oy + 1;
      end else begin
        ox--;
        crit = crit + 2 * (oy - ox) + 1;
      end
    end
  endtask

  task automatic run_draw(input int cx, input int cy, input int r,
                          input logic [7:0] mask, input logic [2:0] col);
    int iters, done_edge, slot, m, ep;
    build_model(cx, cy, r, mask, iters);
    done_edge = 2 + 10 * iters;
    @(negedge clk);
    centre_x = X_W'(cx); centre_y = Y_W'(cy); radius = R_W'(r);
    colour = col; oct_mask = mask; start = 1'b1;
    @(negedge clk);
    // Request has been sampled; scramble inputs to prove they were latched.
    centre_x = X_W'($urandom); centre_y = Y_W'($urandom);
    radius = R_W'($urandom); colour = 3'($urandom); oct_mask = 8'($urandom);
    for (int n = 1; n <= done_edge; n++) begin
      @(negedge clk);
      slot = -1;
      if (n >= 3) begin
        m = n - 3;
        if ((m % 10) < 8 && (m / 10) < iters) slot = (m / 10) * 8 + (m % 10);
      end
      ep = (slot >= 0) ? exp_p[slot] : 0;
      check_val("plot", {31'd0, vga_plot}, ep);
      if (ep != 0) begin
        check_val("x", {24'd0, vga_x}, exp_x[slot]);
        check_val("y", {25'd0, vga_y}, exp_y[slot]);
        check_val("colour", {29'd0, vga_colour}, {29'd0, col});
      end
      check_val("done", {31'd0, done}, (n == done_edge) ? 1 : 0);
    end
    // start still high: must sit in DONE without redrawing.
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check_val("done_hold", {31'd0, done}, 1);
      check_val("plot_hold", {31'd0, vga_plot}, 0);
    end
    start = 1'b0;
    @(negedge clk);
    check_val("done_clear", {31'd0, done}, 0);
    check_val("plot_idle", {31'd0, vga_plot}, 0);
  endtask

  task automatic reset_midplot();
    @(negedge clk);
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd20;
    colour = 3'd5; oct_mask = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    // Third PLOT cycle in progress; second octant pixel (80,80) on the bus.
    check_val("pre_rst_plot", {31'd0, vga_plot}, 1);
    check_val("pre_rst_y", {25'd0, vga_y}, 80);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_plot", {31'd0, vga_plot}, 0);
    check_val("rst_done", {31'd0, done}, 0);
    check_val("rst_x", {24'd0, vga_x}, 0);
    check_val("rst_y", {25'd0, vga_y}, 0);
    check_val("rst_colour", {29'd0, vga_colour}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_plot", {31'd0, vga_plot}, 0);
    check_val("post_rst_done", {31'd0, done}, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    centre_x = '0; centre_y = '0; radius = '0; colour = '0; oct_mask = '0;
    #1;
    check_val("reset_done", {31'd0, done}, 0);
    check_val("reset_plot", {31'd0, vga_plot}, 0);
    check_val("reset_x", {24'd0, vga_x}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_draw(80, 60, 0, 8'hFF, 3'd7);
    run_draw(10, 10, 1, 8'hFF, 3'd3);
    run_draw(80, 60, 10, 8'h01, 3'd1);
    run_draw(0, 0, 5, 8'hFF, 3'd6);
    run_draw(80, 60, 7, 8'h00, 3'd2);
    reset_midplot();
    run_draw(80, 60, 20, 8'hFF, 3'd4);
    run_draw(155, 115, 30, 8'hA5, 3'd5);
    for (int i = 0; i < 10; i++) begin
      run_draw($urandom_range(0, SCREEN_W - 1), $urandom_range(0, SCREEN_H - 1),
               $urandom_range(0, 60), 8'($urandom), 3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stalled clock or scheduling fault.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
